// File: rtl/ifetch_unit_112_pkg.sv
// Shared definitions for the MIPS instruction-fetch slice: opcodes, fetch
// states and instruction field positions.
package ifetch_unit_112_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

endpackage

// File: rtl/npc_112.sv
// Combinational next-PC unit: jump beats taken branch beats sequential.
module npc_112
  import ifetch_unit_112_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] npc
);

  logic        [31:0] pc_plus4;
  logic signed [31:0] branch_off;
  logic        [31:0] branch_tgt;
  logic        [31:0] jump_tgt;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = $signed({{14{imm16[15]}}, imm16, 2'b00});
  assign branch_tgt = pc_plus4 + $unsigned(branch_off);
  assign jump_tgt   = {pc_plus4[31:28], target26, 2'b00};

  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = jump_tgt;
    end else if (branch && zero) begin
      npc = branch_tgt;
    end
  end

endmodule

// File: rtl/ifetch_unit_112.sv
// Instruction fetch for the single-cycle MIPS datapath: PC register,
// word-addressed instruction memory and a load/run/halt controller.
module ifetch_unit_112
  import ifetch_unit_112_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  input  logic              start,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       target26,
  output logic              instr_valid,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;
  // An unaligned RESET_PC is illegal; the low bits are dropped rather than trusted.
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_nxt;
  logic [31:0]  npc;
  logic [31:0]  mem_word;
  logic         mem_we;
  logic [31:0]  mem [DEPTH];

  assign mem_we = imem_we && ((state == S_IDLE) || (state == S_LOAD));

  // Memory content is never reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  assign mem_word = mem[pc[ADDR_W+1:2]];
  assign pc_plus4 = pc + 32'd4;

  // Outside RUN the decoder sees all-zeros, an R-type write to $0.
  assign instr    = (state == S_RUN) ? mem_word : 32'h0;
  assign op       = instr[OP_MSB:OP_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign rt       = instr[RT_MSB:RT_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign shamt    = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct    = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16    = instr[IMM_MSB:IMM_LSB];
  assign target26 = instr[TARGET_MSB:TARGET_LSB];

  assign instr_valid = (state == S_RUN) && (op != HALT_OP);
  assign halted      = (state == S_HALT);

  npc_112 u_npc (
    .pc       (pc),
    .imm16    (imm16),
    .target26 (target26),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .npc      (npc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= START_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    unique case (state)
      S_IDLE: begin
        if (load_en) begin
          state_nxt = S_LOAD;
        end else if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_LOAD: begin
        if (!load_en) begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // The halt word is not stepped over, so pc parks on it.
        if (!stall) begin
          if (op == HALT_OP) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt = npc;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = START_PC;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_unit_112.sv
// Directed bench for ifetch_unit_112: load/run/halt, branch, jump,
// stall, write lockout, async reset and restart.
module tb_ifetch_unit_112;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              load_en;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              start;
  logic              stall;
  logic              branch;
  logic              zero;
  logic              jump;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [31:0]       instr;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [25:0]       target26;
  logic              instr_valid;
  logic              halted;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_unit_112 #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .HALT_OP  (6'h3F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .start       (start),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .target26    (target26),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    step();
    imem_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    start = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    rst = 1'b0;
    step();

    // Program 1: ori, ori, addu, halt
    load_en = 1'b1;
    step();
    wr(8'd0, 32'h3401_0005);
    wr(8'd1, 32'h3402_0003);
    wr(8'd2, 32'h0022_1821);
    wr(8'd3, 32'hFC00_0000);
    load_en = 1'b0;
    step();
    chk("idle_instr", instr, 32'h0);
    pulse_start();
    chk("p1_pc0", pc, 32'h0);
    chk("p1_op0", {26'b0, op}, 32'h0D);
    chk("p1_imm0", {16'b0, imm16}, 32'h5);
    chk("p1_rt0", {27'b0, rt}, 32'h1);
    chk("p1_valid0", {31'b0, instr_valid}, 32'h1);
    chk("p1_pc4_0", pc_plus4, 32'h4);
    step();
    chk("p1_pc1", pc, 32'h4);
    chk("p1_op1", {26'b0, op}, 32'h0D);
    step();
    chk("p1_pc2", pc, 32'h8);
    chk("p1_op2", {26'b0, op}, 32'h00);
    chk("p1_rs2", {27'b0, rs}, 32'h1);
    chk("p1_rd2", {27'b0, rd}, 32'h3);
    chk("p1_funct2", {26'b0, funct}, 32'h21);
    step();
    chk("p1_pc3", pc, 32'hC);
    chk("p1_op3", {26'b0, op}, 32'h3F);
    chk("p1_valid3", {31'b0, instr_valid}, 32'h0);
    chk("p1_halted3", {31'b0, halted}, 32'h0);
    step();
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_pc", pc, 32'hC);
    chk("halt_valid", {31'b0, instr_valid}, 32'h0);
    chk("halt_instr", instr, 32'h0);
    // a write attempted in HALT must not land
    wr(8'd0, 32'hDEAD_BEEF);
    step();
    chk("halt_hold_pc", pc, 32'hC);
    pulse_start();
    chk("restart1_pc", pc, 32'h0);
    chk("restart1_valid", {31'b0, instr_valid}, 32'h1);
    chk("restart1_instr", instr, 32'h3401_0005);

    // Program 2: branch/jump/stall tests
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
    chk("rst2_pc", pc, 32'h0);
    load_en = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_start_ignored", {31'b0, instr_valid}, 32'h0);
    wr(8'd0, 32'h0000_0000);
    wr(8'd1, 32'h0800_0010);
    wr(8'd2, 32'h1022_FFFE);
    wr(8'd3, 32'h0000_0000);
    wr(8'd16, 32'hFC00_0000);
    load_en = 1'b0;
    step();
    pulse_start();
    chk("p2_pc0", pc, 32'h0);
    chk("p2_valid0", {31'b0, instr_valid}, 32'h1);
    step();
    chk("p2_pc1", pc, 32'h4);
    chk("p2_instr1", instr, 32'h0800_0010);
    stall = 1'b1;
    imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h4);
      chk("stall_halted", {31'b0, halted}, 32'h0);
    end
    stall = 1'b0; imem_we = 1'b0;
    chk("run_wr_lockout", instr, 32'h0800_0010);
    chk("target26", {6'b0, target26}, 32'h10);
    step();
    chk("p2_pc2", pc, 32'h8);
    chk("p2_instr2", instr, 32'h1022_FFFE);
    branch = 1'b1; zero = 1'b1;
    step();
    chk("br_taken_pc", pc, 32'h4);
    jump = 1'b1;
    step();
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    chk("jump_prec_pc", pc, 32'h40);
    chk("jump_op", {26'b0, op}, 32'h3F);
    stall = 1'b1;
    step();
    chk("stall_no_halt", {31'b0, halted}, 32'h0);
    chk("stall_halt_pc", pc, 32'h40);
    stall = 1'b0;
    step();
    chk("halt2_flag", {31'b0, halted}, 32'h1);
    chk("halt2_pc", pc, 32'h40);
    pulse_start();
    chk("restart2_pc", pc, 32'h0);
    chk("restart2_valid", {31'b0, instr_valid}, 32'h1);
    chk("restart2_halted", {31'b0, halted}, 32'h0);
    step();
    step();
    chk("pre_rst_pc", pc, 32'h8);

    // asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_halted", {31'b0, halted}, 32'h0);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_pc", pc, 32'h0);
    pulse_start();
    chk("rerun_pc0", pc, 32'h0);
    chk("rerun_valid0", {31'b0, instr_valid}, 32'h1);
    step();
    chk("rerun_instr1", instr, 32'h0800_0010);
    step();
    chk("rerun_pc2", pc, 32'h8);
    chk("rerun_instr2", instr, 32'h1022_FFFE);
    branch = 1'b1; zero = 1'b0;
    step();
    branch = 1'b0;
    chk("br_not_taken_pc", pc, 32'hC);
    chk("br_not_taken_pc4", pc_plus4, 32'h10);
    chk("br_not_taken_valid", {31'b0, instr_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit_112.md
Name: ifetch_unit_112

Overview:
- Instruction-fetch end of the single-cycle MIPS datapath: holds the PC and a word-addressed instruction memory.
- Presents the current instruction and its split fields (op, rs, rt, rd, shamt, funct, imm16, target26) to the main control decoder and register file.
- Consumes the decoder's Branch/Jump outputs and the ALU Zero flag to form the next PC.
- Adds a load/run/halt state machine so a bench or loader can fill memory before execution.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth = 2**ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value after reset and on restart; must be word-aligned.
- HALT_OP, 6'h3F, opcode that stops fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  request loader mode.
- imem_we  in  1  instruction-memory write strobe.
- imem_waddr  in  ADDR_W  word address for write.
- imem_wdata  in  32  instruction word to write.
- start  in  1  one-cycle pulse to begin or restart execution.
- stall  in  1  hold PC this cycle.
- branch  in  1  Branch from the control decoder.
- zero  in  1  ALU Zero flag.
- jump  in  1  Jump from the control decoder.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4.
- instr  out  32  current instruction; 0 when not RUN.
- op  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- target26  out  26  instr[25:0].
- instr_valid  out  1  instr is a real fetched instruction.
- halted  out  1  state==HALT.

Behaviour:
- Reset (async, any state, including mid-RUN): pc=RESET_PC, state=IDLE, instr=0, instr_valid=0, halted=0. Memory contents are not cleared.
- States:
  - IDLE: load_en=1 -> LOAD; else start=1 -> RUN.
  - LOAD: load_en=0 -> IDLE. start while load_en=1 is ignored.
  - RUN: fetched op==HALT_OP and stall=0 -> HALT.
  - HALT: start -> RUN with pc<=RESET_PC.
- Memory writes: when imem_we=1 in IDLE or LOAD, mem[imem_waddr]<=imem_wdata at the clock edge. Writes in RUN or HALT are ignored.
- Read path: asynchronous, mem[pc[ADDR_W+1:2]]. Upper PC bits are ignored, so addresses wrap modulo depth. Zero cycles from PC to instr.
- instr = (state==RUN) ? mem word : 32'h0. The 0 is a NOP to the decoder: R-type writes $0, which is harmless.
- instr_valid = (state==RUN) && op!=HALT_OP.
- Next PC in RUN with stall=0, evaluated in this priority order:
  - jump=1: {pc_plus4[31:28], target26, 2'b00}.
  - branch=1 and zero=1: pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, 32-bit with wrap.
  - otherwise: pc_plus4.
- jump and branch both asserted: jump wins. branch=1 with zero=0: sequential.
- stall=1 holds pc, and no halt transition occurs that cycle.
- HALT instruction: pc is not advanced, so pc stays at the halt word.
- pc_plus4 is combinational pc+32'd4 (wraps at 2**32).
- IDLE/LOAD/HALT: pc holds. branch, jump and zero are don't-care.
- start asserted in RUN is ignored.
- RESET_PC with low bits !=00 is illegal; the low 2 bits of pc are forced to 00 on load.

Decomposition:
- Shared package holds:
  - opcode constants (R_TYPE 6'h00, J 6'h02, BEQ 6'h04, ORI 6'h0D, ADDIU 6'h09, LW 6'h23, SW 6'h2B, HALT 6'h3F);
  - fetch state enum {IDLE, LOAD, RUN, HALT};
  - instruction field bit-position constants.
- One natural sub-module: npc_112, the combinational next-PC unit (pc, imm16, target26, branch, zero, jump -> npc). The top module keeps state, the PC register and memory.

Test Plan:
- Load and run: load mem[0..3]=34010005, 34020003, 00221821, FC000000, then start. Required: pc 0,4,8,C; op sequence 0D,0D,00,3F; then halted=1, pc=C, instr_valid=0.
- Branch taken: mem[2]=1022FFFE with branch=1, zero=1 at pc=8. Required: next pc=8+4-8=4. Same cycle with zero=0: next pc=C.
- Jump precedence: mem[1]=08000010, jump=1 and branch=1, zero=1 at pc=4. Required: next pc=0x40.
- Stall and write lockout: stall=1 for 3 cycles at pc=4 -> pc stays 4, no halt. imem_we during RUN to addr 1 -> mem[1] unchanged on later readback.
- Reset mid-run: rst pulsed asynchronously (not clock-aligned) at pc=8. Required: pc=0, state IDLE, instr=0, instr_valid=0 immediately. After start, pc restarts at 0 and memory is still intact.
- Restart from HALT: in HALT, start pulse. Required: pc=RESET_PC, RUN, instr_valid=1 next cycle.
